// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - frame controller around the fft core
// Loads one frame of samples, waits for compute, then streams the bins out.
module fft_sequencer #(
  parameter int width   = 16,
  parameter int N_2     = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [width-1:0]   sample_in,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               fft_clear,
  output logic               fft_load,
  output logic [width-1:0]   fft_rd,
  output logic               fft_start,
  input  logic               fft_done,
  output logic [N_2-1:0]     fft_rdadr,
  input  logic [2*width-1:0] fft_wd,
  output logic [2*width-1:0] out_data,
  output logic [N_2-1:0]     out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun,
  output logic               timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [N_2:0]  FRAME_LEN = {1'b1, {N_2{1'b0}}};
  localparam logic [N_2:0]  LAST_BIN  = {1'b0, {N_2{1'b1}}};
  localparam logic [N_2:0]  CNT_ONE   = {{N_2{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_COMPUTE,
    S_FETCH,
    S_PRESENT
  } state_t;

  state_t             state_q, state_d;
  logic [N_2:0]       smp_cnt_q, smp_cnt_d;
  logic [N_2:0]       bin_cnt_q, bin_cnt_d;
  logic [TW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [TW-1:0]      tmo_inc;
  logic               fft_load_q, fft_load_d;
  logic [width-1:0]   fft_rd_q, fft_rd_d;
  logic [2*width-1:0] out_data_q, out_data_d;
  logic [N_2-1:0]     out_idx_q, out_idx_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               accept;

  assign tmo_inc = tmo_cnt_q + TMO_ONE;

  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = smp_cnt_q;
    bin_cnt_d    = bin_cnt_q;
    tmo_cnt_d    = '0;
    fft_load_d   = 1'b0;
    fft_rd_d     = fft_rd_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;
    sample_ready = 1'b0;
    fft_clear    = 1'b0;
    fft_start    = 1'b0;
    out_valid    = 1'b0;
    frame_done   = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fft_clear = 1'b1;
        smp_cnt_d = '0;
        bin_cnt_d = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        // A full counter closes the port for one cycle so fft_start trails the last load.
        sample_ready = (smp_cnt_q != FRAME_LEN);
        accept       = sample_ready && sample_valid;
        if (accept) begin
          smp_cnt_d  = smp_cnt_q + CNT_ONE;
          fft_load_d = 1'b1;
          fft_rd_d   = sample_in;
        end
        if (smp_cnt_q == FRAME_LEN) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        fft_start = 1'b1;
        tmo_cnt_d = tmo_inc;
        if (fft_done) begin
          bin_cnt_d = '0;
          state_d   = S_FETCH;
        end else if (tmo_inc == TMAX) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_FETCH: begin
        out_data_d = fft_wd;
        out_idx_d  = bin_cnt_q[N_2-1:0];
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (bin_cnt_q == LAST_BIN) begin
            frame_done = 1'b1;
            state_d    = run ? S_CLEAR : S_IDLE;
          end else begin
            bin_cnt_d = bin_cnt_q + CNT_ONE;
            state_d   = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An idle controller with run low is not expecting data, so offers then are not overruns.
    if (sample_valid && (state_q != S_LOAD) && ((state_q != S_IDLE) || run))
      overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      smp_cnt_q  <= '0;
      bin_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      fft_load_q <= 1'b0;
      fft_rd_q   <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      bin_cnt_q  <= bin_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      fft_load_q <= fft_load_d;
      fft_rd_q   <= fft_rd_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign fft_load  = fft_load_q;
  assign fft_rd    = fft_rd_q;
  assign fft_rdadr = bin_cnt_q[N_2-1:0];
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule
